// File: rtl/mem_key_sequencer_pkg.sv
// Shared constants for the MEM front-end: character width, letter range, key digit width
// and FSM state codes.
package mem_key_sequencer_pkg;

    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned DEF_SET_W = 2;

    localparam logic [CHAR_W-1:0] ASCII_A = 8'h41;
    localparam logic [CHAR_W-1:0] ASCII_Z = 8'h5A;

    localparam logic [0:0] ST_NOKEY = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    function automatic logic is_letter(input logic [CHAR_W-1:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

endpackage

// File: rtl/mem_key_ring.sv
// Key register plus digit position counter; presents the digit currently selected by the
// position. Digit 0 sits in the most significant bits of the key.
module mem_key_ring
    import mem_key_sequencer_pkg::*;
#(
    parameter int unsigned KEY_LEN = 4,
    parameter int unsigned SET_W   = DEF_SET_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [SET_W*KEY_LEN-1:0]   key_in,
    input  logic                       rewind,
    input  logic                       step,
    output logic [SET_W-1:0]           digit,
    output logic [$clog2(KEY_LEN)-1:0] pos
);

    localparam int unsigned POS_W = $clog2(KEY_LEN);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(KEY_LEN - 1);

    logic [SET_W*KEY_LEN-1:0] key_q;
    logic [POS_W-1:0]         pos_q, pos_d;

    // Rewind outranks a step taken in the same cycle.
    always_comb begin
        pos_d = pos_q;
        if (load || rewind) begin
            pos_d = '0;
        end else if (step) begin
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
            pos_q <= '0;
        end else begin
            if (load) begin
                key_q <= key_in;
            end
            pos_q <= pos_d;
        end
    end

    always_comb begin
        digit = '0;
        for (int unsigned i = 0; i < KEY_LEN; i++) begin
            if (pos_q == POS_W'(i)) begin
                digit = key_q[(KEY_LEN-1-i)*SET_W +: SET_W];
            end
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/mem_key_sequencer.sv
// Front-end controller for the MEM datapath: character handshake, key stepping and a
// one-entry output buffer that sustains one character per cycle.
module mem_key_sequencer
    import mem_key_sequencer_pkg::*;
#(
    parameter int unsigned KEY_LEN = 4,
    parameter int unsigned SET_W   = DEF_SET_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_load,
    input  logic [SET_W*KEY_LEN-1:0]   key_in,
    input  logic                       msg_start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHAR_W-1:0]          in_char,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHAR_W-1:0]          out_char,
    output logic [SET_W-1:0]           mem_setting,
    output logic [CHAR_W-1:0]          mem_in,
    input  logic [CHAR_W-1:0]          mem_out,
    output logic [$clog2(KEY_LEN)-1:0] key_pos,
    output logic                       key_valid
);

    logic [0:0]        state_q;
    logic              out_valid_q;
    logic [CHAR_W-1:0] out_char_q;
    logic              accept;
    logic              letter;

    assign key_valid = (state_q == ST_READY);
    assign in_ready  = key_valid & ~key_load & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign letter    = is_letter(in_char);
    assign mem_in    = in_char;

    mem_key_ring #(
        .KEY_LEN (KEY_LEN),
        .SET_W   (SET_W)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .load   (key_load),
        .key_in (key_in),
        .rewind (msg_start),
        .step   (accept & letter),
        .digit  (mem_setting),
        .pos    (key_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NOKEY;
        end else if (key_load) begin
            state_q <= ST_READY;
        end
    end

    // A fresh accept overwrites a buffer being drained in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_char_q  <= letter ? mem_out : in_char;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;

endmodule

// File: tb/tb_mem_key_sequencer.sv
// Bench for mem_key_sequencer with a stand-in MEM (one reflector per setting) and a
// cycle-level reference model of the handshake, key stepping and output buffer.
module tb_mem_key_sequencer;

    localparam int unsigned KEY_LEN = 4;
    localparam int unsigned SET_W   = 2;

    logic       clk = 1'b0;
    logic       rst, key_load, msg_start, in_valid, out_ready;
    logic [7:0] key_in, in_char, mem_in, mem_out, out_char;
    logic       in_ready, out_valid, key_valid;
    logic [1:0] mem_setting, key_pos;

    int checks = 0;
    int errors = 0;

    int         m_key [KEY_LEN];
    int         m_pos;
    bit         m_kv, m_ov;
    logic [7:0] m_oc;

    bit         obs_rdy, exp_rdy, obs_take;
    logic [1:0] obs_set;
    int         exp_set;
    logic [7:0] obs_char;

    always #5 clk = ~clk;

    // Reciprocal substitution per setting, so the same key both encrypts and decrypts.
    function automatic logic [7:0] mem_ref(input logic [1:0] s, input logic [7:0] c);
        string t;
        case (s)
            2'd0:    t = "OCBEDGFIHKJYNMAQPSRUTWVZLX";
            2'd1:    t = "BADCSGFIHLWJNMPORQEUTXKVZY";
            2'd2:    t = "BAHLFEOCJIMDKPGNRQTSVUXWZY";
            default: t = "BADCFEIRGKJQNMPOLHTSVUXWZY";
        endcase
        if (c < 8'h41 || c > 8'h5A) return 8'h3F;
        return t[int'(c) - 65];
    endfunction

    function automatic bit is_alpha(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    assign mem_out = mem_ref(mem_setting, mem_in);

    mem_key_sequencer #(
        .KEY_LEN (KEY_LEN),
        .SET_W   (SET_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_load    (key_load),
        .key_in      (key_in),
        .msg_start   (msg_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char),
        .mem_setting (mem_setting),
        .mem_in      (mem_in),
        .mem_out     (mem_out),
        .key_pos     (key_pos),
        .key_valid   (key_valid)
    );

    task automatic model_update();
        bit rdy, acc, let_c;
        if (rst) begin
            m_kv = 0; m_pos = 0; m_ov = 0; m_oc = 8'h00;
            for (int i = 0; i < KEY_LEN; i++) m_key[i] = 0;
        end else begin
            rdy   = m_kv && !key_load && (!m_ov || out_ready);
            acc   = in_valid && rdy;
            let_c = is_alpha(in_char);
            if (acc) begin
                m_oc = let_c ? mem_ref(2'(m_key[m_pos]), in_char) : in_char;
                m_ov = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (key_load) begin
                for (int i = 0; i < KEY_LEN; i++) m_key[i] = int'(key_in[(3-i)*2 +: 2]);
                m_kv  = 1;
                m_pos = 0;
            end else if (msg_start) begin
                m_pos = 0;
            end else if (acc && let_c) begin
                m_pos = (m_pos + 1) % KEY_LEN;
            end
        end
    endtask

    // Samples the pre-edge combinational view, clocks once, then advances the model.
    task automatic step();
        #1;
        obs_rdy  = in_ready;
        obs_set  = mem_setting;
        obs_take = out_valid && out_ready;
        obs_char = out_char;
        exp_rdy  = m_kv && !key_load && (!m_ov || out_ready);
        exp_set  = m_key[m_pos];
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic test_reset();
        rst = 1; key_load = 0; key_in = 8'h00; msg_start = 0;
        in_valid = 1; in_char = "A"; out_ready = 1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL reset_out_char: got %h expected 00", out_char); end
        checks++; if (key_pos !== 2'd0) begin errors++; $display("FAIL reset_key_pos: got %0d expected 0", key_pos); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        checks++; if (mem_setting !== 2'd0) begin errors++; $display("FAIL reset_mem_setting: got %0d expected 0", mem_setting); end
        checks++; if (mem_in !== in_char) begin errors++; $display("FAIL reset_mem_in: got %h expected %h", mem_in, in_char); end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL nokey_in_ready: got %b expected 0", obs_rdy); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nokey_out_valid: got %b expected 0", out_valid); end
        end
    endtask

    task automatic run_message(input string name, input string src, input string want);
        in_valid = 0; msg_start = 1; step(); msg_start = 0;
        checks++; if (key_pos !== 2'd0) begin errors++; $display("FAIL %s_rewind: got %0d expected 0", name, key_pos); end
        for (int i = 0; i < src.len(); i++) begin
            in_valid = 1; in_char = src[i]; out_ready = 1;
            step();
            checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL %s_in_ready[%0d]: got %b expected 1", name, i, obs_rdy); end
            checks++; if (obs_set !== 2'(exp_set)) begin errors++; $display("FAIL %s_setting[%0d]: got %0d expected %0d", name, i, obs_set, exp_set); end
            checks++; if (out_valid !== 1'b1 || out_char !== want[i]) begin errors++; $display("FAIL %s_char[%0d]: got %b/%h expected 1/%h", name, i, out_valid, out_char, want[i]); end
            checks++; if (key_pos !== 2'(m_pos)) begin errors++; $display("FAIL %s_key_pos[%0d]: got %0d expected %0d", name, i, key_pos, m_pos); end
        end
        in_valid = 0; step();
    endtask

    task automatic test_encrypt();
        key_load = 1; key_in = 8'b10_01_00_11; in_valid = 1; in_char = "H"; out_ready = 1;
        step();
        key_load = 0;
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL load_in_ready: got %b expected 0", obs_rdy); end
        checks++; if (key_valid !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL load_state: got kv=%b ov=%b expected 1/0", key_valid, out_valid); end
        run_message("enc", "HELLOWORLD", "CSYQGKAHDC");
    endtask

    task automatic test_decrypt();
        checks++; if (key_pos !== 2'd2) begin errors++; $display("FAIL dec_pre_pos: got %0d expected 2", key_pos); end
        run_message("dec", "CSYQGKAHDC", "HELLOWORLD");
    endtask

    task automatic test_nonletter();
        run_message("nonletter", "HE LO", "CS YP");
        checks++; if (m_pos !== 0 || key_pos !== 2'd0) begin errors++; $display("FAIL nonletter_final_pos: got %0d expected 0", key_pos); end
    endtask

    task automatic test_backpressure();
        string      want;
        string      src;
        logic [7:0] got [$];
        logic [7:0] saved;
        want = "CSYQG"; src = "HELLO";
        in_valid = 0; out_ready = 1; msg_start = 1; step(); msg_start = 0;
        in_valid = 1; in_char = src[0]; out_ready = 0;
        step();
        if (obs_take) got.push_back(obs_char);
        checks++; if (out_valid !== 1'b1 || out_char !== want[0]) begin errors++; $display("FAIL bp_first: got %b/%h expected 1/%h", out_valid, out_char, want[0]); end
        saved = out_char;
        in_char = src[1];
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs_take) got.push_back(obs_char);
            checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, obs_rdy); end
            checks++; if (out_valid !== 1'b1 || out_char !== saved) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", i, out_valid, out_char, saved); end
        end
        out_ready = 1;
        for (int i = 1; i < 5; i++) begin
            in_char = src[i];
            step();
            if (obs_take) got.push_back(obs_char);
            checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_ready[%0d]: got %b expected 1", i, obs_rdy); end
        end
        in_valid = 0;
        step(); if (obs_take) got.push_back(obs_char);
        step(); if (obs_take) got.push_back(obs_char);
        checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL bp_stream[%0d]: got %h expected %h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_midload();
        in_valid = 0; out_ready = 1; msg_start = 1; step(); msg_start = 0;
        in_valid = 1; in_char = "H"; step();
        in_char = "E"; step();
        key_load = 1; key_in = 8'b01_11_10_00; in_char = "L"; out_ready = 0;
        step();
        key_load = 0;
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL midload_in_ready: got %b expected 0", obs_rdy); end
        checks++; if (out_valid !== 1'b1 || out_char !== 8'h53) begin errors++; $display("FAIL midload_pending: got %b/%h expected 1/53", out_valid, out_char); end
        checks++; if (key_pos !== 2'd0) begin errors++; $display("FAIL midload_key_pos: got %0d expected 0", key_pos); end
        out_ready = 1;
        step();
        checks++; if (obs_rdy !== 1'b1 || obs_set !== 2'd1) begin errors++; $display("FAIL midload_digit0: got rdy=%b set=%0d expected 1/1", obs_rdy, obs_set); end
        checks++; if (out_char !== 8'h4A) begin errors++; $display("FAIL midload_char: got %h expected 4a", out_char); end
        in_valid = 0; step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            key_load  = ($urandom_range(0, 39) == 0);
            key_in    = 8'($urandom);
            msg_start = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_char   = ($urandom_range(0, 4) != 0) ? 8'(65 + $urandom_range(0, 25))
                                                    : 8'($urandom_range(32, 126));
            step();
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", n, obs_rdy, exp_rdy); end
            checks++; if (obs_set !== 2'(exp_set)) begin errors++; $display("FAIL rnd_setting[%0d]: got %0d expected %0d", n, obs_set, exp_set); end
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", n, out_valid, m_ov); end
            checks++; if (out_char !== m_oc) begin errors++; $display("FAIL rnd_out_char[%0d]: got %h expected %h", n, out_char, m_oc); end
            checks++; if (key_pos !== 2'(m_pos) || key_valid !== m_kv) begin errors++; $display("FAIL rnd_key[%0d]: got pos=%0d kv=%b expected %0d/%b", n, key_pos, key_valid, m_pos, m_kv); end
        end
        key_load = 0; msg_start = 0; in_valid = 0; out_ready = 1; step();
    endtask

    task automatic test_reset_mid();
        msg_start = 1; step(); msg_start = 0;
        in_valid = 1; in_char = "H"; step();
        in_char = "E"; step();
        checks++; if (out_valid !== 1'b1 || key_pos !== 2'd2) begin errors++; $display("FAIL rstmid_pre: got ov=%b pos=%0d expected 1/2", out_valid, key_pos); end
        in_valid = 0; out_ready = 0; rst = 1;
        step();
        rst = 0;
        checks++; if (out_valid !== 1'b0 || out_char !== 8'h00) begin errors++; $display("FAIL rstmid_out: got %b/%h expected 0/00", out_valid, out_char); end
        checks++; if (key_pos !== 2'd0 || key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_key: got pos=%0d kv=%b expected 0/0", key_pos, key_valid); end
        in_valid = 1; in_char = "A"; out_ready = 1;
        step();
        checks++; if (obs_rdy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_blocked: got rdy=%b ov=%b expected 0/0", obs_rdy, out_valid); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_nonletter();
        test_backpressure();
        test_midload();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
